imem_responder: RTL and testbench

- Instruction-memory responder: the memory end of the fetch interface.
- Accepts one word-read request from the fetch stage and returns the 32-bit instruction after a fixed, parameterised latency, using a valid/ready handshake on both request and response.
- Contains a word-addressed instruction store written through a separate program-load port used by benches and boot logic.
- Sits between the fetch stage (request initiator) and the fetch/decode pipeline register (response consumer).

---
 rtl/imem_responder.sv | 165 ++++++++++++++++
 tb/tb_imem_responder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Memory end of the instruction-fetch interface. Accepts one word-read request
// at a time, returns the 32-bit instruction a fixed LATENCY cycles later, and
// flags misaligned or out-of-range requests with a NOP payload. The word store
// is written through an independent program-load port.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   req_valid_i    fetch request valid
//   req_addr_i     byte address of the requested instruction
//   req_ready_o    responder can accept a request this cycle
//   rsp_valid_o    response valid
//   rsp_instr_o    instruction word (NOP on error)
//   rsp_err_o      request was misaligned or out of range
//   rsp_ready_i    consumer accepts the response
//   load_en_i      program-load write strobe
//   load_addr_i    word index for the load write
//   load_data_i    load write data
//   rsp_count_o    count of completed responses (wraps)
//   busy_o         a request is in flight
// -----------------------------------------------------------------------------
module imem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           req_valid_i,
   input  logic [31:0]                    req_addr_i,
   output logic                           req_ready_o,
   output logic                           rsp_valid_o,
   output logic [31:0]                    rsp_instr_o,
   output logic                           rsp_err_o,
   input  logic                           rsp_ready_i,
   input  logic                           load_en_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
   input  logic [31:0]                    load_data_i,
   output logic [15:0]                    rsp_count_o,
   output logic                           busy_o
);

   localparam int          AW  = $clog2(DEPTH_WORDS);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [31:0]   addr_reg, addr_next;
   logic [3:0]    cnt_reg, cnt_next;
   logic [15:0]   count_reg, count_next;
   logic [31:0]   instr_reg;
   logic          err_reg;

   logic [31:0]   store [DEPTH_WORDS];

   logic          accept;
   logic          do_read;
   logic [31:0]   read_addr;
   logic [AW-1:0] read_idx;
   logic          read_err;

   assign req_ready_o = (state_reg == IDLE) & ~load_en_i & ~rst_i;
   assign accept      = req_valid_i & req_ready_o;

   // With LATENCY==1 the read happens on the accept edge itself, before
   // addr_reg has captured the request, so the live request address is used
   // while idle.
   assign read_addr = (state_reg == IDLE) ? req_addr_i : addr_reg;
   assign read_idx  = read_addr[AW+1:2];
   assign read_err  = (read_addr[1:0] != 2'b00) | (read_addr[31:AW+2] != '0);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      cnt_next   = cnt_reg;
      count_next = count_reg;
      do_read    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               addr_next = req_addr_i;
               if (LATENCY == 1) begin
                  state_next = RESP;
                  do_read    = 1'b1;
               end else begin
                  state_next = WAIT;
                  cnt_next   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            // Counter value 1 marks the last waiting cycle: the read result
            // lands in the output register on this edge.
            if (cnt_reg == 4'd1) begin
               state_next = RESP;
               do_read    = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_next = IDLE;
               count_next = count_reg + 16'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State and response registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         cnt_reg   <= '0;
         count_reg <= '0;
         instr_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         cnt_reg   <= cnt_next;
         count_reg <= count_next;
         if (do_read) begin
            err_reg <= read_err;
            // The store array sees the pre-edge contents, so a load to the
            // same word on this edge yields the old data.
            if (read_err) begin
               instr_reg <= NOP;
            end else begin
               instr_reg <= store[read_idx];
            end
         end
      end
   end

   // Store contents are deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (load_en_i) begin
         store[load_addr_i] <= load_data_i;
      end
   end

   assign rsp_valid_o = (state_reg == RESP);
   assign rsp_instr_o = instr_reg;
   assign rsp_err_o   = err_reg;
   assign rsp_count_o = count_reg;
   assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//
// Three responders (LATENCY 1, 2 and 15, DEPTH_WORDS 256) share one clock and
// reset. A transaction-level model tracks each one; a compare process checks
// every DUT output against it at each falling edge, and directed sequences add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_imem_responder;

   localparam int NI    = 3;
   localparam int DEPTH = 256;

   int LAT [NI] = '{1, 2, 15};

   logic        clk;
   logic        rst;
   logic        req_valid [NI];
   logic [31:0] req_addr  [NI];
   logic        req_ready [NI];
   logic        rsp_valid [NI];
   logic [31:0] rsp_instr [NI];
   logic        rsp_err   [NI];
   logic        rsp_ready [NI];
   logic        load_en   [NI];
   logic [7:0]  load_addr [NI];
   logic [31:0] load_data [NI];
   logic [15:0] rsp_count [NI];
   logic        busy      [NI];

   int checks   = 0;
   int failures = 0;

   imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid[0]), .req_addr_i(req_addr[0]), .req_ready_o(req_ready[0]),
      .rsp_valid_o(rsp_valid[0]), .rsp_instr_o(rsp_instr[0]), .rsp_err_o(rsp_err[0]),
      .rsp_ready_i(rsp_ready[0]), .load_en_i(load_en[0]), .load_addr_i(load_addr[0]),
      .load_data_i(load_data[0]), .rsp_count_o(rsp_count[0]), .busy_o(busy[0]));

   imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_l2 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid[1]), .req_addr_i(req_addr[1]), .req_ready_o(req_ready[1]),
      .rsp_valid_o(rsp_valid[1]), .rsp_instr_o(rsp_instr[1]), .rsp_err_o(rsp_err[1]),
      .rsp_ready_i(rsp_ready[1]), .load_en_i(load_en[1]), .load_addr_i(load_addr[1]),
      .load_data_i(load_data[1]), .rsp_count_o(rsp_count[1]), .busy_o(busy[1]));

   imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(15)) u_l15 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid[2]), .req_addr_i(req_addr[2]), .req_ready_o(req_ready[2]),
      .rsp_valid_o(rsp_valid[2]), .rsp_instr_o(rsp_instr[2]), .rsp_err_o(rsp_err[2]),
      .rsp_ready_i(rsp_ready[2]), .load_en_i(load_en[2]), .load_addr_i(load_addr[2]),
      .load_data_i(load_data[2]), .rsp_count_o(rsp_count[2]), .busy_o(busy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // -------------------------------------------------------------------------
   // Reference model: one outstanding request per responder; the response
   // becomes visible LATENCY-1 edges after the accept edge (so the consumer
   // samples it on the LATENCY-th edge) and is computed from the store as it
   // stood before that edge's load write.
   // -------------------------------------------------------------------------
   logic [31:0] m_mem   [NI][DEPTH];
   bit          m_busy  [NI] = '{0, 0, 0};
   bit          m_valid [NI] = '{0, 0, 0};
   logic [31:0] m_instr [NI] = '{0, 0, 0};
   bit          m_err   [NI] = '{0, 0, 0};
   logic [15:0] m_count [NI] = '{0, 0, 0};
   logic [31:0] m_addr  [NI];
   longint      m_acc   [NI];
   longint      cyc = 0;

   function automatic void m_respond(int i);
      logic [31:0] a;
      a = m_addr[i];
      m_err[i] = (a % 4 != 0) || (a >= 32'(4 * DEPTH));
      if (m_err[i]) m_instr[i] = 32'h0000_0013;
      else          m_instr[i] = m_mem[i][a / 4];
      m_valid[i] = 1'b1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NI; i++) begin
            m_busy[i]  = 1'b0;
            m_valid[i] = 1'b0;
            m_instr[i] = '0;
            m_err[i]   = 1'b0;
            m_count[i] = '0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            if (m_valid[i]) begin
               if (rsp_ready[i]) begin
                  m_valid[i] = 1'b0;
                  m_busy[i]  = 1'b0;
                  m_count[i] = m_count[i] + 16'd1;
                  $display("txn inst=%0d lat=%0d addr=%08h instr=%08h err=%0d count=%0d",
                           i, LAT[i], m_addr[i], m_instr[i], m_err[i], m_count[i]);
               end
            end else if (m_busy[i]) begin
               if (cyc - m_acc[i] == longint'(LAT[i] - 1)) m_respond(i);
            end else if (req_valid[i] && !load_en[i]) begin
               m_busy[i] = 1'b1;
               m_acc[i]  = cyc;
               m_addr[i] = req_addr[i];
               if (LAT[i] == 1) m_respond(i);
            end
            if (load_en[i]) m_mem[i][load_addr[i]] = load_data[i];
         end
         cyc++;
      end
   end

   task automatic chk(input string name, input int inst, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d actual=%08h required=%08h t=%0t", name, inst, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         chk("cyc_rsp_valid", i, 32'(rsp_valid[i]), 32'(m_valid[i]));
         chk("cyc_busy",      i, 32'(busy[i]),      32'(m_busy[i]));
         chk("cyc_count",     i, 32'(rsp_count[i]), 32'(m_count[i]));
         chk("cyc_req_ready", i, 32'(req_ready[i]),
             32'(!m_busy[i] && !load_en[i] && !rst));
         if (m_valid[i]) begin
            chk("cyc_instr", i, rsp_instr[i], m_instr[i]);
            chk("cyc_err",   i, 32'(rsp_err[i]), 32'(m_err[i]));
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stimulus helpers (all start and end at posedge + 1)
   // -------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int i, input logic [31:0] addr);
      bit ok;
      ok           = 1'b0;
      req_valid[i] = 1'b1;
      req_addr[i]  = addr;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         if (req_ready[i]) ok = 1'b1;
         step();
      end
      req_valid[i] = 1'b0;
      chk("accept", i, 32'(ok), 32'd1);
   endtask

   // Returns the number of rising edges, counted from the accept edge, up to
   // the edge at which the consumer first sees rsp_valid_o high.
   task automatic wait_rsp(input int i, output int sp, output logic [31:0] ins,
                           output logic er);
      sp  = -1;
      ins = '0;
      er  = 1'b0;
      for (int k = 1; k <= 40 && sp < 0; k++) begin
         @(negedge clk);
         if (rsp_valid[i]) begin
            sp  = k;
            ins = rsp_instr[i];
            er  = rsp_err[i];
         end
      end
   endtask

   task automatic run_basic(input int i);
      int sp; logic [31:0] ins; logic er;
      rsp_ready[i] = 1'b1;
      issue(i, 32'h0);
      wait_rsp(i, sp, ins, er);
      chk("spacing_a0", i, sp, LAT[i]);
      chk("instr_a0", i, ins, 32'h0050_0093);
      chk("err_a0", i, 32'(er), 32'd0);
      step();
      issue(i, 32'h4);
      wait_rsp(i, sp, ins, er);
      chk("spacing_a4", i, sp, LAT[i]);
      chk("instr_a4", i, ins, 32'h0010_8113);
      chk("err_a4", i, 32'(er), 32'd0);
      step();
      @(negedge clk);
      chk("count_2", i, 32'(rsp_count[i]), 32'd2);
      step();
      issue(i, 32'h6);
      wait_rsp(i, sp, ins, er);
      chk("instr_misaligned", i, ins, 32'h0000_0013);
      chk("err_misaligned", i, 32'(er), 32'd1);
      step();
      issue(i, 32'h400);
      wait_rsp(i, sp, ins, er);
      chk("instr_range", i, ins, 32'h0000_0013);
      chk("err_range", i, 32'(er), 32'd1);
      step();
      @(negedge clk);
      chk("count_4", i, 32'(rsp_count[i]), 32'd4);
      step();
   endtask

   task automatic run_bp(input int i);
      int sp; logic [31:0] ins; logic er;
      rsp_ready[i] = 1'b0;
      issue(i, 32'h4);
      wait_rsp(i, sp, ins, er);
      chk("bp_first_instr", i, ins, 32'h0010_8113);
      for (int k = 0; k < 5; k++) begin
         step();
         req_valid[i] = (k % 2 == 0);
         req_addr[i]  = 32'h0;
         @(negedge clk);
         chk("bp_valid", i, 32'(rsp_valid[i]), 32'd1);
         chk("bp_instr", i, rsp_instr[i], 32'h0010_8113);
         chk("bp_err", i, 32'(rsp_err[i]), 32'd0);
         chk("bp_req_ready", i, 32'(req_ready[i]), 32'd0);
      end
      step();
      req_valid[i] = 1'b0;
      rsp_ready[i] = 1'b1;
      step();
      @(negedge clk);
      chk("bp_done_valid", i, 32'(rsp_valid[i]), 32'd0);
      chk("bp_done_busy", i, 32'(busy[i]), 32'd0);
      chk("bp_done_count", i, 32'(rsp_count[i]), 32'd5);
      step();
   endtask

   task automatic run_ld(input int i);
      int sp; logic [31:0] ins; logic er; logic [31:0] d;
      d            = $urandom;
      load_en[i]   = 1'b1;
      load_addr[i] = 8'd10;
      load_data[i] = d;
      req_valid[i] = 1'b1;
      req_addr[i]  = 32'd40;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("ld_req_ready", i, 32'(req_ready[i]), 32'd0);
         step();
      end
      load_en[i] = 1'b0;
      @(negedge clk);
      chk("ld_req_ready_after", i, 32'(req_ready[i]), 32'd1);
      step();
      req_valid[i] = 1'b0;
      wait_rsp(i, sp, ins, er);
      chk("ld_spacing", i, sp, LAT[i]);
      chk("ld_instr", i, ins, d);
      step();
   endtask

   task automatic run_rand(input int i);
      int r;
      for (int c = 0; c < 400; c++) begin
         req_valid[i] = ($urandom_range(0, 2) != 0);
         r = $urandom_range(0, 9);
         if (r < 7)      req_addr[i] = {22'b0, 8'($urandom), 2'b00};
         else if (r < 8) req_addr[i] = {22'b0, 8'($urandom), 2'($urandom_range(1, 3))};
         else            req_addr[i] = $urandom | 32'h0000_0400;
         rsp_ready[i] = ($urandom_range(0, 3) != 0);
         load_en[i]   = ($urandom_range(0, 4) == 0);
         load_addr[i] = 8'($urandom);
         load_data[i] = $urandom;
         step();
      end
      req_valid[i] = 1'b0;
      load_en[i]   = 1'b0;
      rsp_ready[i] = 1'b1;
   endtask

   // -------------------------------------------------------------------------
   // Main sequence
   // -------------------------------------------------------------------------
   initial begin
      int sp; logic [31:0] ins; logic er;
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         req_valid[i] = 1'b0; req_addr[i] = '0; rsp_ready[i] = 1'b1;
         load_en[i] = 1'b0; load_addr[i] = '0; load_data[i] = '0;
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk("rst_valid", i, 32'(rsp_valid[i]), 32'd0);
         chk("rst_instr", i, rsp_instr[i], 32'd0);
         chk("rst_err",   i, 32'(rsp_err[i]), 32'd0);
         chk("rst_count", i, 32'(rsp_count[i]), 32'd0);
         chk("rst_busy",  i, 32'(busy[i]), 32'd0);
         chk("rst_ready", i, 32'(req_ready[i]), 32'd0);
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) chk("idle_ready", i, 32'(req_ready[i]), 32'd1);
      step();

      // Program load of the whole store.
      for (int w = 0; w < DEPTH; w++) begin
         for (int i = 0; i < NI; i++) begin
            load_en[i]   = 1'b1;
            load_addr[i] = 8'(w);
            case (w)
               0:       load_data[i] = 32'h0050_0093;
               1:       load_data[i] = 32'h0010_8113;
               8:       load_data[i] = 32'h1234_5678;
               default: load_data[i] = $urandom;
            endcase
         end
         step();
      end
      for (int i = 0; i < NI; i++) load_en[i] = 1'b0;

      fork run_basic(0); run_basic(1); run_basic(2); join
      fork run_bp(0);    run_bp(1);    run_bp(2);    join
      fork run_ld(0);    run_ld(1);    run_ld(2);    join

      // Load on the read edge returns old data; an earlier load is visible.
      issue(1, 32'h20);
      load_en[1] = 1'b1; load_addr[1] = 8'd8; load_data[1] = 32'hDEAD_BEEF;
      step();
      load_en[1] = 1'b0;
      wait_rsp(1, sp, ins, er);
      chk("rdw_old_data", 1, ins, 32'h1234_5678);
      step();
      issue(1, 32'h20);
      wait_rsp(1, sp, ins, er);
      chk("rdw_written", 1, ins, 32'hDEAD_BEEF);
      step();
      issue(2, 32'h20);
      load_en[2] = 1'b1; load_addr[2] = 8'd8; load_data[2] = 32'hCAFE_F00D;
      step();
      load_en[2] = 1'b0;
      wait_rsp(2, sp, ins, er);
      chk("wait_write_visible", 2, ins, 32'hCAFE_F00D);
      step();

      // Reset while a LATENCY=15 request is waiting.
      issue(2, 32'h0);
      step();
      step();
      rst = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) begin
         chk("midrst_busy",  i, 32'(busy[i]), 32'd0);
         chk("midrst_valid", i, 32'(rsp_valid[i]), 32'd0);
         chk("midrst_count", i, 32'(rsp_count[i]), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("midrst_no_rsp", 2, 32'(rsp_valid[2]), 32'd0);
      end
      step();

      // Completion counter wrap.
      force u_l1.count_reg = 16'hFFFF;
      m_count[0] = 16'hFFFF;
      #1;
      release u_l1.count_reg;
      @(negedge clk);
      chk("wrap_pre", 0, 32'(rsp_count[0]), 32'h0000_FFFF);
      step();
      issue(0, 32'h4);
      wait_rsp(0, sp, ins, er);
      chk("wrap_spacing", 0, sp, 1);
      step();
      @(negedge clk);
      chk("wrap_post", 0, 32'(rsp_count[0]), 32'd0);
      step();

      fork run_rand(0); run_rand(1); run_rand(2); join
      repeat (40) step();
      for (int i = 0; i < NI; i++) chk("drain_idle", i, 32'(busy[i]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
